sim_ahb_arb2: RTL
=================

SIM_AHB_ARB2 -- requirements
Module: sim_ahb_arb2

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, address width.
REQ-002 SHALL have parameter W_DATA, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for each upstream n in {0,1}, ports:
- sn_haddr  input  W_ADDR
- sn_hwrite  input  1
- sn_htrans  input  2
- sn_hsize  input  3
- sn_hwdata  input  W_DATA
- sn_hready  output  1
- sn_hresp  output  1
- sn_hrdata  output  W_DATA
REQ-006 SHALL have downstream ports ahblm_haddr/hwrite/htrans/hsize/hwdata as outputs, and ahblm_hready/hresp/hrdata as inputs, with widths as in REQ-005.

Function
REQ-007 SHALL share one AHB-Lite slave (simulation control) between two AHB-Lite masters with no upstream hready input.
REQ-008 SHALL treat an upstream request as live when sn_htrans[1]=1 and sn_hready=1 in the same cycle.
REQ-009 SHALL hold one pending buffer per upstream (addr, write, size, valid).
REQ-010 SHALL grant only in cycles with ahblm_hready=1, in fixed order: pending0, pending1, live0, live1.
REQ-011 SHALL drive a granted request onto ahblm_* combinationally, with ahblm_htrans=2'b10 (SEQ converted to NONSEQ). Live grants add zero cycles.
REQ-012 SHALL drive ahblm_htrans=2'b00 and ahblm_haddr=0 when nothing is granted.
REQ-013 SHALL capture a live, ungranted request (contention or ahblm_hready=0) into that port's pending buffer at the clock edge.
REQ-014 SHALL clear a pending buffer on the edge at which its grant is accepted.
REQ-015 SHALL register the data-phase owner (none/0/1) on each edge where ahblm_hready=1; it becomes the granted port, or none if nothing is granted.
REQ-016 SHALL compute sn_hready as:
- ahblm_hready if port n is the data-phase owner;
- else 0 if port n's pending buffer is valid;
- else 1.
REQ-017 SHALL forward ahblm_hresp and ahblm_hrdata to the owner only; non-owners get hresp=0 and hrdata=0.
REQ-018 SHALL mux ahblm_hwdata from the owner's sn_hwdata, and drive 0 when there is no owner.
REQ-019 SHALL pass an error response (two-cycle hresp=1) to the owner only, and SHALL NOT cancel the other port's pending buffer.
REQ-020 SHALL, while ahblm_hready=0, leave the owner unchanged and grant nothing; new live requests are buffered.
REQ-021 SHALL ignore a port's live input while its buffer is valid, since that port's hready is 0 and no request can be live.

Reset
REQ-022 SHALL, on rst_n low, immediately clear both pending buffers and set owner to none, including mid-transfer; in-flight transfers are dropped.
REQ-023 SHALL hold these values during reset: s0/s1_hready=1, hresp=0, hrdata=0, ahblm_htrans=0, ahblm_haddr=0, ahblm_hwdata=0.
REQ-024 SHALL start normal arbitration on the first clock edge after rst_n rises.

Verification
REQ-025 Single live write:
- Stimulus: s0 writes 0x08 with hwdata 0x2A; ahblm_hready=1.
- Required: ahblm_htrans=2'b10, haddr=0x08 in the same cycle; next cycle ahblm_hwdata=0x2A, s0_hready=1; zero added latency.
REQ-026 Simultaneous requests:
- Stimulus: s0 writes 0x00, s1 writes 0x04 in the same cycle.
- Required: s0 granted first and s1 buffered; s1_hready=0 for one cycle; s1 addr 0x04 granted next cycle; s1 hwdata forwarded during its data phase.
REQ-027 Downstream stall:
- Stimulus: ahblm_hready=0 for 3 cycles during s0's data phase while s1 issues 0x10.
- Required: s0_hready=0 for 3 cycles, s1 buffered, no new downstream address; s1 granted in the first cycle ahblm_hready=1.
REQ-028 Anti-starvation:
- Stimulus: s1 pending while s0 issues back-to-back live reads.
- Required: the pending s1 request wins the next grant over live s0.
REQ-029 Error routing:
- Stimulus: slave returns two-cycle hresp=1 to s1 while s0 is pending.
- Required: s1_hresp=1 for 2 cycles, s1_hready=0 then 1; s0_hresp stays 0; s0 pending still granted afterwards.
REQ-030 Async reset:
- Stimulus: rst_n asserted mid data phase with s1 pending.
- Required: same cycle s0/s1_hready=1, ahblm_htrans=0, pending cleared; no grant of the old s1 request after release.

Source files
------------

// File: rtl/sim_ahb_arb2.sv
// Two-master to one-slave AHB-Lite arbiter for the simulation-control slave.
// Live requests pass through combinationally; losers wait in a per-port pending buffer.
module sim_ahb_arb2 #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [W_ADDR-1:0] s0_haddr,
  input  logic              s0_hwrite,
  input  logic [1:0]        s0_htrans,
  input  logic [2:0]        s0_hsize,
  input  logic [W_DATA-1:0] s0_hwdata,
  output logic              s0_hready,
  output logic              s0_hresp,
  output logic [W_DATA-1:0] s0_hrdata,

  input  logic [W_ADDR-1:0] s1_haddr,
  input  logic              s1_hwrite,
  input  logic [1:0]        s1_htrans,
  input  logic [2:0]        s1_hsize,
  input  logic [W_DATA-1:0] s1_hwdata,
  output logic              s1_hready,
  output logic              s1_hresp,
  output logic [W_DATA-1:0] s1_hrdata,

  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  output logic [W_DATA-1:0] ahblm_hwdata,
  input  logic              ahblm_hready,
  input  logic              ahblm_hresp,
  input  logic [W_DATA-1:0] ahblm_hrdata
);

  typedef enum logic [2:0] {GntNone, GntPend0, GntPend1, GntLive0, GntLive1} gnt_e;
  typedef enum logic [1:0] {OwnNone, Own0, Own1} own_e;

  logic              pend0_v_q, pend0_v_d, pend1_v_q, pend1_v_d;
  logic [W_ADDR-1:0] pend0_addr_q, pend0_addr_d, pend1_addr_q, pend1_addr_d;
  logic              pend0_write_q, pend0_write_d, pend1_write_q, pend1_write_d;
  logic [2:0]        pend0_size_q, pend0_size_d, pend1_size_q, pend1_size_d;
  own_e              own_q, own_d;

  logic live0, live1;
  gnt_e gnt;

  always_comb begin
    s0_hready = (own_q == Own0) ? ahblm_hready : ~pend0_v_q;
    s1_hready = (own_q == Own1) ? ahblm_hready : ~pend1_v_q;
    s0_hresp  = (own_q == Own0) ? ahblm_hresp  : 1'b0;
    s1_hresp  = (own_q == Own1) ? ahblm_hresp  : 1'b0;
    s0_hrdata = (own_q == Own0) ? ahblm_hrdata : '0;
    s1_hrdata = (own_q == Own1) ? ahblm_hrdata : '0;
    unique case (own_q)
      Own0:    ahblm_hwdata = s0_hwdata;
      Own1:    ahblm_hwdata = s1_hwdata;
      default: ahblm_hwdata = '0;
    endcase
  end

  // A port with a valid buffer has hready low, so its live input is meaningless.
  assign live0 = s0_htrans[1] & s0_hready & ~pend0_v_q;
  assign live1 = s1_htrans[1] & s1_hready & ~pend1_v_q;

  // Fixed priority: buffered requests first so a waiting port cannot starve.
  always_comb begin
    gnt = GntNone;
    if (rst_n && ahblm_hready) begin
      if (pend0_v_q)      gnt = GntPend0;
      else if (pend1_v_q) gnt = GntPend1;
      else if (live0)     gnt = GntLive0;
      else if (live1)     gnt = GntLive1;
    end
  end

  always_comb begin
    ahblm_haddr  = '0;
    ahblm_hwrite = 1'b0;
    ahblm_hsize  = 3'b000;
    ahblm_htrans = 2'b00;
    unique case (gnt)
      GntPend0: begin
        ahblm_haddr  = pend0_addr_q;
        ahblm_hwrite = pend0_write_q;
        ahblm_hsize  = pend0_size_q;
        ahblm_htrans = 2'b10;
      end
      GntPend1: begin
        ahblm_haddr  = pend1_addr_q;
        ahblm_hwrite = pend1_write_q;
        ahblm_hsize  = pend1_size_q;
        ahblm_htrans = 2'b10;
      end
      GntLive0: begin
        ahblm_haddr  = s0_haddr;
        ahblm_hwrite = s0_hwrite;
        ahblm_hsize  = s0_hsize;
        ahblm_htrans = 2'b10;
      end
      GntLive1: begin
        ahblm_haddr  = s1_haddr;
        ahblm_hwrite = s1_hwrite;
        ahblm_hsize  = s1_hsize;
        ahblm_htrans = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    own_d = own_q;
    if (ahblm_hready) begin
      unique case (gnt)
        GntPend0, GntLive0: own_d = Own0;
        GntPend1, GntLive1: own_d = Own1;
        default:            own_d = OwnNone;
      endcase
    end

    pend0_v_d     = pend0_v_q;
    pend0_addr_d  = pend0_addr_q;
    pend0_write_d = pend0_write_q;
    pend0_size_d  = pend0_size_q;
    if (gnt == GntPend0) pend0_v_d = 1'b0;
    if (live0 && gnt != GntLive0) begin
      pend0_v_d     = 1'b1;
      pend0_addr_d  = s0_haddr;
      pend0_write_d = s0_hwrite;
      pend0_size_d  = s0_hsize;
    end

    pend1_v_d     = pend1_v_q;
    pend1_addr_d  = pend1_addr_q;
    pend1_write_d = pend1_write_q;
    pend1_size_d  = pend1_size_q;
    if (gnt == GntPend1) pend1_v_d = 1'b0;
    if (live1 && gnt != GntLive1) begin
      pend1_v_d     = 1'b1;
      pend1_addr_d  = s1_haddr;
      pend1_write_d = s1_hwrite;
      pend1_size_d  = s1_hsize;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q         <= OwnNone;
      pend0_v_q     <= 1'b0;
      pend0_addr_q  <= '0;
      pend0_write_q <= 1'b0;
      pend0_size_q  <= 3'b000;
      pend1_v_q     <= 1'b0;
      pend1_addr_q  <= '0;
      pend1_write_q <= 1'b0;
      pend1_size_q  <= 3'b000;
    end else begin
      own_q         <= own_d;
      pend0_v_q     <= pend0_v_d;
      pend0_addr_q  <= pend0_addr_d;
      pend0_write_q <= pend0_write_d;
      pend0_size_q  <= pend0_size_d;
      pend1_v_q     <= pend1_v_d;
      pend1_addr_q  <= pend1_addr_d;
      pend1_write_q <= pend1_write_d;
      pend1_size_q  <= pend1_size_d;
    end
  end

endmodule
